word_frame_sync: RTL and testbench
==================================

// Module: word_frame_sync
// PURPOSE
//  Downstream consumer of the 16-bit serial-to-parallel stage. Takes that stage's parallel word and its
//  load strobe, brings the strobe into the clk domain, and hunts for a frame sync word. Once aligned, it
//  forwards payload words through a small show-ahead FIFO using a valid/ready handshake, with a
//  start-of-frame mark on the first word of each frame.
// PARAMETERS
//  SYNC_WORD   16'hA5C3  frame delimiter word, one per frame ahead of the payload
//  FRAME_LEN   8         payload words per frame (>=1)
//  MISS_MAX    3         consecutive sync misses that drop lock and return to HUNT (>=1)
//  FIFO_DEPTH  4         output FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1   single clock; all logic on its rising edge
//  clrs       in   1   synchronous, active-high reset
//  pword_i    in   16  parallel word from the deserializer; changes only on a conp_i rising edge
//  conp_i     in   1   deserializer load strobe; asynchronous to clk
//  m_data     out  16  payload word at the FIFO head
//  m_sof      out  1   m_data is the first payload word of a frame
//  m_valid    out  1   FIFO not empty
//  m_ready    in   1   consumer accepts; transfer occurs when m_valid & m_ready at a clk edge
//  locked     out  1   high while state != HUNT
//  sync_miss  out  1   1-cycle pulse when a sync slot holds the wrong word
//  overflow   out  1   sticky; set when a payload word is dropped because the FIFO is full
// BEHAVIOUR
//  Reset (clrs=1 at a clk edge): state=HUNT; sync chain, miss_cnt, word_cnt and FIFO pointers cleared.
//   Outputs: m_valid=0, m_sof=0, m_data=0, locked=0, sync_miss=0, overflow=0.
//   Reset mid-frame discards the partial frame and all FIFO contents.
//  Strobe capture: conp_i goes through a 3-flop chain s1->s2->s3. evt = s2 & ~s3.
//   When evt=1, pword_i is registered into word_q and stb_q=1 for one cycle.
//   Constraint: conp_i high >=2 clk, low >=2 clk, period >=4 clk; pword_i stays stable between strobes.
//   If conp_i is still high when reset releases, this yields one capture event. That is the required behaviour.
//  FSM (acts on stb_q; no change when stb_q=0):
//   HUNT:    word_q==SYNC_WORD -> PAYLOAD, word_cnt=0, miss_cnt=0; otherwise stay. Nothing is pushed.
//   PAYLOAD: push {sof=(word_cnt==0), word_q}; word_cnt++; when word_cnt==FRAME_LEN-1 -> CHECK.
//   CHECK:   if word_q==SYNC_WORD -> PAYLOAD, miss_cnt=0.
//            Otherwise sync_miss=1 and miss_cnt++.
//            If miss_cnt+1==MISS_MAX -> HUNT and locked=0.
//            Otherwise flywheel: treat the slot as sync and go to PAYLOAD.
//   The sync word itself is never pushed.
//  Latency: a payload word is visible on m_data with m_valid=1 after the 4th clk edge that samples conp_i
//   high (edges: s1, s2, word_q, FIFO push). This holds when the FIFO was empty.
//  FIFO: show-ahead, so m_data/m_sof are driven from the head entry, and both are 0 when empty.
//   Push is accepted if not full, or if a pop occurs in the same cycle.
//   Otherwise the word is dropped and overflow is set; overflow clears only on reset.
//   Simultaneous push and pop on an empty FIFO: the pop is not valid (m_valid=0) and the push succeeds.
//   Pointers wrap modulo FIFO_DEPTH. count holds log2(FIFO_DEPTH)+1 bits.
// STRUCTURE
//  Package word_sync_pkg: fsm_state_t {HUNT, PAYLOAD, CHECK}, default SYNC_WORD, WORD_W=16.
//  Sub-module word_fifo (WIDTH=17, DEPTH): show-ahead synchronous FIFO, push/pop/full/empty.
//  Top level holds the synchronizer, word_q, FSM and counters, plus one word_fifo instance.
// TESTING
//  1 Reset: drive clrs for 2 cycles with random pword_i and conp_i.
//    -> all outputs 0, state HUNT.
//  2 Lock: send A5C3 then 0001..0008 with m_ready=1.
//    -> 8 transfers in order, m_sof only on 0001, locked rises after the A5C3 capture.
//    -> latency of 4 edges for each word.
//  3 Flywheel: lock, send 0000 in place of the 2nd sync, then a good frame.
//    -> one sync_miss pulse, locked stays 1, payload still forwarded, miss_cnt clears on the next sync.
//  4 Loss of lock: three consecutive bad sync slots.
//    -> three sync_miss pulses, locked=0 after the 3rd, later words not forwarded until A5C3 reappears.
//  5 Overflow: m_ready=0, send 1 frame of 8 words.
//    -> first 4 words held, overflow=1, then on m_ready=1 exactly 0001..0004 drain.
//  6 Reset mid-frame after 3 payload words.
//    -> FIFO empty, locked=0, and the next A5C3 frame is forwarded with m_sof set on its first word.

Source files
------------

// File: rtl/word_sync_pkg.sv
// rtl/word_sync_pkg.sv - shared types and constants for the word frame synchronizer
package word_sync_pkg;

   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] DEF_SYNC_WORD = 16'hA5C3;

   typedef enum logic [1:0] {
      HUNT,
      PAYLOAD,
      CHECK
   } fsm_state_t;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - show-ahead synchronous FIFO with push/pop handshake
module word_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             clrs,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             push_ok
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   // a pop on an empty FIFO is ignored; a pop on a full FIFO frees a slot for a same-cycle push
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   // head entry is presented directly; zero while nothing is stored
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // storage array, written only on accepted pushes
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // pointers wrap naturally at DEPTH (power of two); count tracks occupancy
   always_ff @(posedge clk) begin
      if (clrs) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/word_frame_sync.sv
// rtl/word_frame_sync.sv - strobe capture, frame sync hunt/flywheel and payload forwarding
module word_frame_sync
   import word_sync_pkg::*;
#(
   parameter logic [WORD_W-1:0] SYNC_WORD  = DEF_SYNC_WORD,
   parameter int                FRAME_LEN  = 8,
   parameter int                MISS_MAX   = 3,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              clrs,
   input  logic [WORD_W-1:0] pword_i,
   input  logic              conp_i,
   output logic [WORD_W-1:0] m_data,
   output logic              m_sof,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              locked,
   output logic              sync_miss,
   output logic              overflow
);

   localparam int WCW = $clog2(FRAME_LEN + 1);
   localparam int MCW = $clog2(MISS_MAX + 1);
   localparam logic [WCW-1:0] LAST_IDX  = WCW'(FRAME_LEN - 1);
   localparam logic [MCW-1:0] MISS_LAST = MCW'(MISS_MAX - 1);

   logic              s1, s2, s3;
   logic              evt;
   logic [WORD_W-1:0] word_q;
   logic              stb_q;
   fsm_state_t        state;
   logic [WCW-1:0]    word_cnt;
   logic [MCW-1:0]    miss_cnt;
   logic              push;
   logic              push_ok;
   logic              fifo_empty;
   logic [WORD_W:0]   fifo_wdata;
   logic [WORD_W:0]   fifo_rdata;

   // rising edge of the strobe once it has settled through two flops
   assign evt = s2 & ~s3;

   // bring the asynchronous strobe into clk and latch the word on its rising edge
   always_ff @(posedge clk) begin
      if (clrs) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         s3     <= 1'b0;
         stb_q  <= 1'b0;
         word_q <= '0;
      end else begin
         s1    <= conp_i;
         s2    <= s1;
         s3    <= s2;
         stb_q <= evt;
         if (evt) begin
            word_q <= pword_i;
         end
      end
   end

   assign push       = stb_q && (state == PAYLOAD);
   assign fifo_wdata = {(word_cnt == '0), word_q};

   // frame alignment: hunt for sync, count payload, check each sync slot with flywheel tolerance
   always_ff @(posedge clk) begin
      if (clrs) begin
         state     <= HUNT;
         word_cnt  <= '0;
         miss_cnt  <= '0;
         locked    <= 1'b0;
         sync_miss <= 1'b0;
      end else begin
         sync_miss <= 1'b0;
         if (stb_q) begin
            case (state)
               HUNT: begin
                  if (word_q == SYNC_WORD) begin
                     state    <= PAYLOAD;
                     word_cnt <= '0;
                     miss_cnt <= '0;
                     locked   <= 1'b1;
                  end
               end
               PAYLOAD: begin
                  word_cnt <= word_cnt + 1'b1;
                  if (word_cnt == LAST_IDX) begin
                     state <= CHECK;
                  end
               end
               CHECK: begin
                  word_cnt <= '0;
                  if (word_q == SYNC_WORD) begin
                     state    <= PAYLOAD;
                     miss_cnt <= '0;
                  end else begin
                     sync_miss <= 1'b1;
                     if (miss_cnt == MISS_LAST) begin
                        state    <= HUNT;
                        locked   <= 1'b0;
                        miss_cnt <= '0;
                     end else begin
                        state    <= PAYLOAD;
                        miss_cnt <= miss_cnt + 1'b1;
                     end
                  end
               end
               default: begin
                  state  <= HUNT;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

   // sticky record of any payload word lost to a full FIFO
   always_ff @(posedge clk) begin
      if (clrs) begin
         overflow <= 1'b0;
      end else if (push && !push_ok) begin
         overflow <= 1'b1;
      end
   end

   word_fifo #(
      .WIDTH (WORD_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .clrs    (clrs),
      .push    (push),
      .wdata   (fifo_wdata),
      .pop     (m_ready),
      .rdata   (fifo_rdata),
      .empty   (fifo_empty),
      .push_ok (push_ok)
   );

   assign m_valid = ~fifo_empty;
   assign m_sof   = fifo_rdata[WORD_W];
   assign m_data  = fifo_rdata[WORD_W-1:0];

endmodule

// File: tb/tb_word_frame_sync.sv
// tb/tb_word_frame_sync.sv - randomized scoreboard bench for word_frame_sync
module tb_word_frame_sync;

   localparam logic [15:0] SYNC  = 16'hA5C3;
   localparam int          FL    = 8;
   localparam int          MM    = 3;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        clrs;
   logic [15:0] pword_i;
   logic        conp_i;
   logic [15:0] m_data;
   logic        m_sof;
   logic        m_valid;
   logic        m_ready;
   logic        locked;
   logic        sync_miss;
   logic        overflow;

   word_frame_sync #(
      .SYNC_WORD  (SYNC),
      .FRAME_LEN  (FL),
      .MISS_MAX   (MM),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .clrs      (clrs),
      .pword_i   (pword_i),
      .conp_i    (conp_i),
      .m_data    (m_data),
      .m_sof     (m_sof),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .locked    (locked),
      .sync_miss (sync_miss),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sof;
      logic [15:0] data;
      int          t;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   act_miss = 0;
   int   exp_miss = 0;

   // word-level reference: position within the frame and consecutive misses
   bit   m_lk = 1'b0;
   int   m_pos = 0;
   int   m_misses = 0;
   bit   exp_ovf = 1'b0;
   bit   lat_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] rnd_nonsync();
      logic [15:0] v;
      v = 16'($urandom);
      if (v == SYNC) v = v ^ 16'h0001;
      return v;
   endfunction

   task automatic push_exp(input logic sof, input logic [15:0] d, input int t);
      exp_t e;
      if (!m_ready && exp_q.size() >= DEPTH) begin
         exp_ovf = 1'b1;
      end else begin
         e.sof  = sof;
         e.data = d;
         e.t    = t;
         exp_q.push_back(e);
      end
   endtask

   task automatic model_word(input logic [15:0] w, input int t);
      if (!m_lk) begin
         if (w == SYNC) begin
            m_lk     = 1'b1;
            m_pos    = 0;
            m_misses = 0;
         end
      end else if (m_pos < FL) begin
         push_exp(m_pos == 0, w, t);
         m_pos++;
      end else if (w == SYNC) begin
         m_misses = 0;
         m_pos    = 0;
      end else begin
         exp_miss++;
         m_misses++;
         if (m_misses == MM) m_lk = 1'b0;
         else m_pos = 0;
      end
   endtask

   task automatic send_word(input logic [15:0] w);
      @(posedge clk);
      #1;
      model_word(w, lat_on ? cyc + 4 : -1);
      pword_i = w;
      conp_i  = 1'b1;
      repeat ($urandom_range(2, 3)) @(posedge clk);
      #1;
      conp_i = 1'b0;
      repeat ($urandom_range(2, 3)) @(posedge clk);
      #1;
      chk("locked", locked, m_lk);
      chk("overflow", overflow, exp_ovf);
   endtask

   task automatic send_frame(input logic [15:0] s, input bit rnd, input logic [15:0] base);
      send_word(s);
      for (int i = 0; i < FL; i++) begin
         send_word(rnd ? 16'($urandom) : base + 16'(i));
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      clrs    = 1'b1;
      conp_i  = 1'($urandom);
      pword_i = 16'($urandom);
      @(posedge clk);
      #1;
      conp_i  = 1'($urandom);
      pword_i = 16'($urandom);
      @(posedge clk);
      #1;
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_sof", m_sof, 1'b0);
      chk("rst_m_data", m_data, 16'h0);
      chk("rst_locked", locked, 1'b0);
      chk("rst_sync_miss", sync_miss, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      clrs   = 1'b0;
      conp_i = 1'b0;
      m_lk   = 1'b0;
      m_pos  = 0;
      m_misses = 0;
      exp_ovf = 1'b0;
      exp_q.delete();
   endtask

   task automatic end_chk(input string name);
      repeat (3) @(posedge clk);
      #1;
      chk({name, "_pending"}, exp_q.size(), 0);
      chk({name, "_miss_count"}, act_miss, exp_miss);
   endtask

   // cycle counter advanced on each active edge
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // monitor: pops the scoreboard on every accepted transfer
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         if (clrs !== 1'b1) begin
            if (sync_miss) act_miss++;
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_word: got %h sof %b expected none", m_data, m_sof);
               end else begin
                  e = exp_q.pop_front();
                  chk("m_data", m_data, e.data);
                  chk("m_sof", m_sof, e.sof);
                  if (e.t >= 0) chk("latency", cyc, e.t);
               end
            end
            if (!m_valid) chk("idle_head", {m_sof, m_data}, 17'h0);
         end
      end
   end

   initial begin
      clrs    = 1'b1;
      conp_i  = 1'b0;
      pword_i = 16'h0;
      m_ready = 1'b1;

      do_reset();

      lat_on = 1'b1;
      send_word(SYNC);
      for (int i = 1; i <= FL; i++) send_word(16'(i));
      lat_on = 1'b0;
      end_chk("lock");

      send_frame(16'h0000, 1'b0, 16'h0101);
      send_frame(SYNC, 1'b0, 16'h0201);
      end_chk("flywheel");

      send_frame(16'h1234, 1'b0, 16'h0301);
      send_frame(16'h0000, 1'b0, 16'h0401);
      send_word(16'hFFFF);
      for (int i = 0; i < 5; i++) send_word(rnd_nonsync());
      send_frame(SYNC, 1'b1, 16'h0);
      end_chk("lock_loss");

      @(posedge clk);
      #1;
      m_ready = 1'b0;
      send_frame(SYNC, 1'b0, 16'h0001);
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      repeat (10) @(posedge clk);
      end_chk("overflow");

      send_word(SYNC);
      for (int i = 0; i < 3; i++) send_word(16'h0501 + 16'(i));
      do_reset();
      send_frame(SYNC, 1'b0, 16'h0601);
      end_chk("midreset");

      for (int f = 0; f < 30; f++) begin
         send_frame(($urandom_range(0, 3) == 0) ? rnd_nonsync() : SYNC, 1'b1, 16'h0);
      end
      end_chk("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
